// File: rtl/psum_serializer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : psum_serializer_if
//  Purpose  : Vector-in / serial-out bundle between feeder FIFO, serializer
//             and the SFU accumulate stage.
//  Revision : 1.0  initial release
// ============================================================================
interface psum_serializer_if #(
  parameter int PSUM_BW  = 16,
  parameter int INPUT_CH = 16
);
  logic                         start;
  logic [PSUM_BW*INPUT_CH-1:0]  vec_in;
  logic                         vec_valid;
  logic                         vec_ready;
  logic [PSUM_BW-1:0]           psum_in;
  logic                         valid;
  logic                         send_out;
  logic                         busy;
  logic                         done;

  modport master (
    output start, vec_in, vec_valid,
    input  vec_ready, psum_in, valid, send_out, busy, done
  );

  modport slave (
    input  start, vec_in, vec_valid,
    output vec_ready, psum_in, valid, send_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/psum_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : psum_serializer
//  Purpose  : Serializes full-width partial-sum vectors onto the SFU's
//             single-lane stream, lane 0 first, then pulses send_out.
//  Revision : 1.0  initial release
// ============================================================================
module psum_serializer #(
  parameter int PSUM_BW   = 16,
  parameter int INPUT_CH  = 16,
  parameter int NUM_ITERS = 4
) (
  input  logic               clk,
  input  logic               reset,
  psum_serializer_if.slave   bus
);

  localparam int c_VEC_W  = PSUM_BW * INPUT_CH;
  localparam int c_LANE_W = (INPUT_CH  > 1) ? $clog2(INPUT_CH)  : 1;
  localparam int c_ITER_W = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(INPUT_CH - 1);
  localparam logic [c_ITER_W-1:0] c_LAST_ITER = c_ITER_W'(NUM_ITERS - 1);
  localparam logic [c_LANE_W-1:0] c_LANE_ONE  = c_LANE_W'(1);
  localparam logic [c_ITER_W-1:0] c_ITER_ONE  = c_ITER_W'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;
  localparam logic [1:0] c_SEND  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_LANE_W-1:0] r_lane_cnt;
  logic [c_ITER_W-1:0] r_iter_cnt;
  logic [c_VEC_W-1:0]  r_shift;
  logic [PSUM_BW-1:0]  r_psum_in;
  logic                r_valid;
  logic                r_send_out;
  logic                r_done;
  logic                r_busy;

  logic w_vec_ready;
  logic w_hs;
  logic w_last_lane;
  logic w_last_iter;
  logic w_start_acc;
  logic w_valid_nxt;
  logic w_send_nxt;
  logic w_busy_nxt;

  assign w_last_lane = (r_lane_cnt == c_LAST_LANE);
  assign w_last_iter = (r_iter_cnt == c_LAST_ITER);
  assign w_hs        = bus.vec_valid & w_vec_ready;
  // busy stays high through the send_out cycle, so a start there is ignored
  assign w_start_acc = bus.start & ~r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_start_acc) w_state_nxt = c_LOAD;
      c_LOAD:  if (w_hs)        w_state_nxt = c_SHIFT;
      c_SHIFT: begin
        if (w_last_lane) begin
          if (w_last_iter)  w_state_nxt = c_SEND;
          else if (!w_hs)   w_state_nxt = c_LOAD;
        end
      end
      c_SEND:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_vec_ready = 1'b0;
    w_valid_nxt = 1'b0;
    w_send_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    case (r_state)
      c_IDLE:  w_busy_nxt = w_start_acc;
      c_LOAD: begin
        w_vec_ready = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      c_SHIFT: begin
        // reload window only when another vector of this tile is still due
        w_vec_ready = w_last_lane && (r_iter_cnt < c_LAST_ITER);
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      c_SEND: begin
        w_send_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_send_out <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_send_out <= w_send_nxt;
      r_done     <= w_send_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane_cnt <= '0;
      r_iter_cnt <= '0;
      r_shift    <= '0;
      r_psum_in  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start_acc) begin
            r_lane_cnt <= '0;
            r_iter_cnt <= '0;
          end
        end
        c_LOAD: begin
          if (w_hs) begin
            r_shift    <= bus.vec_in;
            r_lane_cnt <= '0;
          end
        end
        c_SHIFT: begin
          r_psum_in <= r_shift[PSUM_BW-1:0];
          r_shift   <= w_hs ? bus.vec_in : (r_shift >> PSUM_BW);
          if (w_last_lane) begin
            r_lane_cnt <= '0;
            r_iter_cnt <= r_iter_cnt + c_ITER_ONE;
          end else begin
            r_lane_cnt <= r_lane_cnt + c_LANE_ONE;
          end
        end
        default: begin
          r_lane_cnt <= r_lane_cnt;
        end
      endcase
    end
  end

  assign bus.vec_ready = w_vec_ready;
  assign bus.psum_in   = r_psum_in;
  assign bus.valid     = r_valid;
  assign bus.send_out  = r_send_out;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_psum_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_psum_serializer
//  Purpose  : Directed scoreboard bench for psum_serializer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_serializer;

  localparam int PSUM_BW   = 16;
  localparam int INPUT_CH  = 16;
  localparam int NUM_ITERS = 4;
  localparam int VEC_W     = PSUM_BW * INPUT_CH;
  localparam int TILE_BEATS = INPUT_CH * NUM_ITERS;

  typedef struct packed {
    logic               is_send;
    logic [PSUM_BW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  psum_serializer_if #(.PSUM_BW(PSUM_BW), .INPUT_CH(INPUT_CH)) bus ();

  psum_serializer #(
    .PSUM_BW  (PSUM_BW),
    .INPUT_CH (INPUT_CH),
    .NUM_ITERS(NUM_ITERS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t exp_q[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   exp_bubbles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or send_out
  int beats, bubbles;
  bit in_tile, prev_valid, chk_fall;
  always @(negedge clk) begin
    if (!reset) begin
      beats = 0; bubbles = 0; in_tile = 0; prev_valid = 0; chk_fall = 0;
    end else begin
      if (chk_fall) begin
        check("busy_fall", bus.busy, 0);
        chk_fall = 0;
      end
      check("done_vs_send", bus.done, bus.send_out);
      if (bus.valid) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          check("beat_kind", m_e.is_send, 0);
          check("beat_data", bus.psum_in, m_e.data);
        end
        beats++;
        in_tile = 1;
      end else if (bus.send_out) begin
        if (exp_q.size() == 0) check("unexpected_send", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          check("send_kind", m_e.is_send, 1);
        end
        check("send_after_last", prev_valid, 1);
        check("send_busy", bus.busy, 1);
        check("tile_beats", beats, TILE_BEATS);
        check("tile_bubbles", bubbles, exp_bubbles);
        beats = 0; bubbles = 0; in_tile = 0; chk_fall = 1;
      end else if (in_tile) begin
        bubbles++;
      end
      prev_valid = bus.valid;
    end
  end

  function automatic logic [VEC_W-1:0] mk_vec(input int v, input bit neg);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int k = 0; k < INPUT_CH; k++)
      r[PSUM_BW*k +: PSUM_BW] = neg ? 16'hFF9C : 16'(16*v + k);
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.vec_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 0, 1);
  endtask

  // Called at a negedge; gap = cycles vec_valid is withheld once ready shows
  task automatic send_vec(input logic [VEC_W-1:0] v, input int gap, input bit last);
    bus.vec_valid = 1'b0;
    wait_ready();
    repeat (gap) @(negedge clk);
    bus.vec_in    = v;
    bus.vec_valid = 1'b1;
    wait_ready();
    for (int k = 0; k < INPUT_CH; k++)
      exp_q.push_back('{is_send: 1'b0, data: v[PSUM_BW*k +: PSUM_BW]});
    if (last) exp_q.push_back('{is_send: 1'b1, data: '0});
    @(posedge clk);
    @(negedge clk);
    bus.vec_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_tile(input int gap2, input int neg_vec, input bit start_glitch);
    int n;
    wait_idle();
    exp_bubbles = gap2;
    pulse_start();
    for (int v = 0; v < NUM_ITERS; v++) begin
      send_vec(mk_vec(v, v == neg_vec), (v == 2) ? gap2 : 0, v == NUM_ITERS - 1);
      if (v == 0 && start_glitch) begin
        repeat (4) @(negedge clk);
        pulse_start();
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("post_tile_busy", bus.busy, 0);
    check("post_tile_valid", bus.valid, 0);
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_psum_in", bus.psum_in, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_send_out", bus.send_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_vec_ready", bus.vec_ready, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_tile(0, -1, 1'b0);   // back-to-back, values 0..63
    run_tile(3, -1, 1'b0);   // 3-cycle hole before vector 2
    run_tile(0, 3, 1'b0);    // vector 3 all lanes -100
    run_tile(0, -1, 1'b1);   // stray start during first vector

    // vec_valid high while idle must be neither consumed nor echoed
    bus.vec_in    = mk_vec(7, 1'b0);
    bus.vec_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_vec_ready", bus.vec_ready, 0);
      check("idle_valid", bus.valid, 0);
    end
    bus.vec_valid = 1'b0;

    // Abort a tile during vector 2, lane 7
    wait_idle();
    exp_bubbles = 0;
    pulse_start();
    send_vec(mk_vec(0, 1'b0), 0, 1'b0);
    send_vec(mk_vec(1, 1'b0), 0, 1'b0);
    send_vec(mk_vec(2, 1'b0), 0, 1'b0);
    n = 0;
    while (!(bus.valid === 1'b1 && bus.psum_in === 16'd39) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("lane39_timeout", 0, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_valid", bus.valid, 0);
    check("abort_send_out", bus.send_out, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_vec_ready", bus.vec_ready, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_send", bus.send_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_tile(0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
